// File: rtl/serial_add_ctrl.sv
// Byte-serial add/subtract sequencer. One 8-bit carry-lookahead slice is reused
// for each byte of a WIDTH-bit operand, LSB first, with a start/done handshake.

module cla8_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       g_out
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Generate/propagate carry chain; g_out is the group generate including c_in.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum   = p ^ c[7:0];
    g_out = c[8];
  end
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);
  localparam int unsigned BEATS = WIDTH / 8;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_lat;
  logic [WIDTH-1:0]   b_lat;
  logic               carry;
  logic [7:0]         a_byte;
  logic [7:0]         b_byte;
  logic [7:0]         slice_sum;
  logic               slice_c;
  logic               accept;
  logic               beat;
  logic               last;

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = ready && start && !flush;
  assign beat   = (state == RUN) && !flush;
  assign last   = (cnt == CNT_W'(BEATS - 1));

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_byte = a_lat[8*i +: 8];
        b_byte = b_lat[8*i +: 8];
      end
    end
  end

  cla8_slice u_slice (
    .a     (a_byte),
    .b     (b_byte),
    .c_in  (carry),
    .sum   (slice_sum),
    .g_out (slice_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        if (flush)      state_nxt = IDLE;
        else if (start) state_nxt = RUN;
        else            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // flush blocks acceptance even from IDLE so state and datapath stay in step
    if (flush && state == IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      carry    <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_lat  <= op_a;
      b_lat  <= sub ? ~op_b : op_b;
      carry  <= sub;
      cnt    <= '0;
      result <= '0;
    end else if (beat) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (cnt == CNT_W'(i)) result[8*i +: 8] <= slice_sum;
      end
      carry <= slice_c;
      if (last) begin
        c_out    <= slice_c;
        overflow <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) && (slice_sum[7] != a_lat[WIDTH-1]);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl against an arithmetic
// reference model (full-width integer add/subtract with signed range check).

module tb_serial_add_ctrl;
  logic        clock;
  logic        reset_n;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        c_out;
  logic        overflow;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_r;
  logic        exp_c;
  logic        exp_v;
  logic        last_c = 1'b0;
  logic        last_v = 1'b0;

  serial_add_ctrl #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] r, output logic c, output logic v);
    longint ua, ub, ur, sa, sb, sr;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ur = s ? (ua - ub) : (ua + ub);
    sr = s ? (sa - sb) : (sa + sb);
    r  = ur[31:0];
    c  = s ? (a >= b) : ur[32];
    v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  // Drives one request and returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int w = 0;
    while (!ready && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    check("ready_before_start", ready, 1);
    ref_op(a, b, s, exp_r, exp_c, exp_v);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    sub   = $urandom_range(0, 1);
    check("busy_after_accept", busy, 1);
  endtask

  // exp_lat < 0 skips latency/busy-length checks (used when cycles were spent elsewhere).
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    int busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_done"}, done, 1);
    if (exp_lat >= 0) begin
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_busy_cycles"}, busy_n, exp_lat);
    end
    check({tag, "_ready"}, ready, 1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_c_out"}, c_out, exp_c);
    check({tag, "_overflow"}, overflow, exp_v);
    last_c = exp_c;
    last_v = exp_v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] corner [6];
    int          done_seen;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h0000_00FF;
    corner[5] = 32'h0000_0001;

    reset_n = 1'b0;
    start   = 1'b0;
    sub     = 1'b0;
    op_a    = '0;
    op_b    = '0;
    flush   = 1'b0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_c_out", c_out, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed corners; done is registered and thus visible 4 edges after accept
    // (a consumer clocking on it sees it at the 5th edge).
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done("ff_plus_1", 4);
    check("ff_plus_1_const", result, 32'h0000_0100);
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("wrap_add", 4);
    check("wrap_add_cout_const", c_out, 1);
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("pos_ovf", 4);
    check("pos_ovf_const", {result, overflow}, {32'h8000_0000, 1'b1});
    start_op(32'd5, 32'd7, 1'b1);
    wait_done("sub_5_7", 4);
    check("sub_5_7_const", {result, c_out}, {32'hFFFF_FFFE, 1'b0});
    start_op(32'h8000_0000, 32'd1, 1'b1);
    wait_done("neg_ovf", 4);
    check("neg_ovf_const", {result, c_out, overflow}, {32'h7FFF_FFFF, 1'b1, 1'b1});

    // Starts during RUN are ignored.
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    op_a = 32'h0BAD_F00D; op_b = 32'h1; start = 1'b1; sub = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    wait_done("ignore_start", -1);

    // Back-to-back accept from DONE.
    start_op(32'h10, 32'h20, 1'b0);
    wait_done("b2b", 4);
    check("b2b_const", result, 32'h0000_0030);

    // Flush at beat 2.
    start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_ready", ready, 1);
    check("flush_done", done, 0);
    check("flush_c_out_held", c_out, last_c);
    check("flush_ovf_held", overflow, last_v);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("flush_no_done", done_seen, 0);

    // Asynchronous reset mid-RUN.
    start_op(32'hFFFF_0000, 32'h0001_FFFF, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("arst_result", result, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    start_op(32'd1, 32'd1, 1'b0);
    wait_done("after_rst", 4);
    check("after_rst_const", result, 32'h0000_0002);

    // Randomized operations, some built from corner values, some back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
      start_op(a, b, 1'($urandom_range(0, 1)));
      wait_done("rand", 4);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
